ahb2_mem_ws: RTL and testbench

//  AHB2 SRAM slave that replaces the fixed 32-bit zero-wait memory model in sim/sverilog.

---
 rtl/ahb2_mem_ws.sv | 170 +++++++++++++++++
 tb/tb_ahb2_mem_ws.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2_mem_ws.sv
// rtl/ahb2_mem_ws.sv - AHB2 SRAM slave with programmable wait states, sized writes and error responses
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   hsel, htrans        slave select, transfer type (htrans[1]=1 -> NONSEQ/SEQ)
//   hwrite, hsize       direction (1=write), transfer size (0=byte .. 3=dword)
//   haddr               32-bit byte address
//   hwdata              write data, valid during the data phase
//   hreadyi             bus ready; previous data phase ends this cycle
//   hrdata              registered read data, non-zero only in the last cycle of a read
//   hresp               0=OKAY, 1=ERROR
//   hreadyo             this slave's data phase completes this cycle
module ahb2_mem_ws #(
  parameter int ADDR_WIDTH  = 18,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hsel,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [31:0]           haddr,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hreadyi,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hresp,
  output logic                  hreadyo
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LB    = $clog2(NB);
  localparam int WW    = ADDR_WIDTH - LB;
  localparam int WORDS = 1 << WW;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {IDLE, WAIT, LAST, ERR1, ERR2} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [2:0]            size_q;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic                  open_slot;
  logic                  accept;
  logic                  bad;
  logic                  commit;
  logic [WW-1:0]         cm_word;
  logic [NB-1:0]         be;
  logic [ADDR_WIDTH-1:0] n_addr;
  logic                  n_write;
  logic [WW-1:0]         n_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_htrans;

  assign unused_htrans = htrans[0];

  // A new address phase may only be taken when our own data phase is ending
  // (or there is none), which is exactly the hreadyo=1 states.
  assign open_slot = (state == IDLE) || (state == LAST) || (state == ERR2);
  assign accept    = hsel & htrans[1] & hreadyi & open_slot;

  assign bad = ((haddr >> ADDR_WIDTH) != 32'd0)
             | (hsize > 3'(LB))
             | ((haddr & ((32'd1 << hsize) - 32'd1)) != 32'd0);

  assign hreadyo = !((state == WAIT) || (state == ERR1));
  assign hresp   = ((state == ERR1) || (state == ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, LAST, ERR2: begin
        state_nxt = IDLE;
        if (accept) begin
          if (bad) begin
            state_nxt = ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_STATES - 1);
          end else begin
            state_nxt = LAST;
          end
        end
      end
      WAIT: begin
        if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
        else             state_nxt = LAST;
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  // The write in its final (LAST) cycle commits at the coming edge.
  assign commit  = (state == LAST) && wr_q;
  assign cm_word = addr_q[ADDR_WIDTH-1:LB];
  assign be      = NB'(((32'd1 << (32'd1 << size_q)) - 32'd1) << addr_q[LB-1:0]);

  // Transfer about to enter LAST: a waited one comes from the capture
  // registers, a zero-wait one straight from the address bus.
  assign n_addr  = (state == WAIT) ? addr_q : haddr[ADDR_WIDTH-1:0];
  assign n_write = (state == WAIT) ? wr_q : hwrite;
  assign n_word  = n_addr[ADDR_WIDTH-1:LB];

  // Memory is sampled on the same edge a preceding write commits, so the
  // written lanes are forwarded from hwdata to return the new value.
  always_comb begin
    rd_word = mem[n_word];
    if (commit && (cm_word == n_word)) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) rd_word[8*i +: 8] = hwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      wr_q   <= 1'b0;
      size_q <= 3'd0;
      hrdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q <= haddr[ADDR_WIDTH-1:0];
        wr_q   <= hwrite;
        size_q <= hsize;
      end
      hrdata <= ((state_nxt == LAST) && !n_write) ? rd_word : '0;
    end
  end

  // No reset on the array: contents survive rst_n, and a write caught by
  // reset before its LAST cycle is simply dropped.
  always_ff @(posedge clk) begin
    if (rst_n && commit) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[cm_word][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  task automatic init_mem();
    for (int i = 0; i < WORDS; i++) mem[i] <= '0;
  endtask

  task automatic init_mem_with_addr();
    for (int i = 0; i < WORDS; i++) mem[i] <= DATA_WIDTH'(i);
  endtask

  task automatic read_word(input logic [ADDR_WIDTH-1:0] addr, output logic [DATA_WIDTH-1:0] rdata);
    rdata = mem[addr[ADDR_WIDTH-1:LB]];
  endtask

  task automatic write_word(input logic [ADDR_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] wdata);
    mem[addr[ADDR_WIDTH-1:LB]] <= wdata;
  endtask

endmodule

// File: tb/tb_ahb2_mem_ws.sv
// tb/tb_ahb2_mem_ws.sv - scoreboard bench for ahb2_mem_ws with 0, 2 and 3 wait states
module tb_ahb2_mem_ws;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int WORDS = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    hsel;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [31:0]   haddr;
  logic [DW-1:0] hwdata;
  logic          hreadyi;
  logic [DW-1:0] hrdata0, hrdata2, hrdata3;
  logic [2:0]    hresp_v, hreadyo_v;

  always #5 clk = ~clk;

  assign hreadyi = &hreadyo_v;

  ahb2_mem_ws #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel[0]), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hreadyi(hreadyi),
    .hrdata(hrdata0), .hresp(hresp_v[0]), .hreadyo(hreadyo_v[0]));

  ahb2_mem_ws #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel[1]), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hreadyi(hreadyi),
    .hrdata(hrdata2), .hresp(hresp_v[1]), .hreadyo(hreadyo_v[1]));

  ahb2_mem_ws #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .hsel(hsel[2]), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hreadyi(hreadyi),
    .hrdata(hrdata3), .hresp(hresp_v[2]), .hreadyo(hreadyo_v[2]));

  typedef struct {
    int          id;
    int          inst;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          id;
    int          inst;
    logic        resp;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  txn_t        stim_q[$];
  exp_t        exp_q[$];
  logic [31:0] model [3][WORDS];
  int          ws_of [3] = '{0, 2, 3};
  int          n_tests = 0;
  int          n_fail  = 0;
  int          next_id = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic add(input int inst, input logic wr, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.id = next_id; t.inst = inst; t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
    next_id++;
    stim_q.push_back(t);
  endtask

  // Reference behaviour: bad transfers error in two cycles with no side
  // effect; good ones update/read a plain byte-lane model in issue order.
  task automatic predict(input txn_t t, output exp_t e);
    int w, lane, n;
    e.id = t.id; e.inst = t.inst; e.rdata = '0;
    if (t.addr >= 32'(1 << AW) || t.size > 3'd2 || (t.addr & ((32'd1 << t.size) - 32'd1)) != 32'd0) begin
      e.resp  = 1'b1;
      e.waits = 1;
    end else begin
      e.resp  = 1'b0;
      e.waits = ws_of[t.inst];
      w    = int'(t.addr >> 2);
      lane = int'(t.addr[1:0]);
      n    = 1 << t.size;
      if (t.wr) begin
        for (int b = lane; b < lane + n; b++) model[t.inst][w][8*b +: 8] = t.wdata[8*b +: 8];
      end else begin
        e.rdata = model[t.inst][w];
      end
    end
  endtask

  function automatic logic [31:0] rd_of(input int inst);
    case (inst)
      0:       return hrdata0;
      1:       return hrdata2;
      default: return hrdata3;
    endcase
  endfunction

  task automatic complete(input int waits);
    exp_t e;
    e = exp_q.pop_front();
    check($sformatf("t%0d i%0d hresp", e.id, e.inst), {31'd0, hresp_v[e.inst]}, {31'd0, e.resp});
    check($sformatf("t%0d i%0d hrdata", e.id, e.inst), rd_of(e.inst), e.rdata);
    check($sformatf("t%0d i%0d waits", e.id, e.inst), 32'(waits), 32'(e.waits));
  endtask

  // Pipelined driver: at each negedge, hreadyi tells whether the coming
  // edge ends the current data phase and accepts the presented address.
  task automatic run_queue();
    txn_t cur;
    exp_t e;
    bit   dp_v  = 1'b0;
    int   waits = 0;
    int   cyc   = 0;
    while ((stim_q.size() > 0 || dp_v) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (dp_v) hwdata = cur.wdata;
      if (hreadyi) begin
        if (dp_v) complete(waits);
        if (stim_q.size() > 0) begin
          cur    = stim_q.pop_front();
          hsel   = 3'b001 << cur.inst;
          htrans = 2'b10;
          hwrite = cur.wr;
          hsize  = cur.size;
          haddr  = cur.addr;
          predict(cur, e);
          exp_q.push_back(e);
          dp_v  = 1'b1;
          waits = 0;
        end else begin
          hsel   = 3'b000;
          htrans = 2'b00;
          dp_v   = 1'b0;
        end
      end else if (dp_v) begin
        waits++;
      end
    end
    check("queue_drained", 32'(stim_q.size()) + 32'(dp_v), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    rst_n  = 1'b0;
    hsel   = 3'b000;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd0;
    haddr  = '0;
    hwdata = '0;
    u_ws0.init_mem();
    u_ws2.init_mem_with_addr();
    u_ws3.init_mem();
    for (int i = 0; i < WORDS; i++) begin
      model[0][i] = '0;
      model[1][i] = 32'(i);
      model[2][i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_hreadyo", {29'd0, hreadyo_v}, 32'h7);
    check("reset_hresp", {29'd0, hresp_v}, 32'h0);
    check("reset_hrdata0", hrdata0, 32'h0);
    check("reset_hrdata3", hrdata3, 32'h0);

    // zero-wait write then back-to-back read
    add(0, 1, 3'd2, 32'h100, 32'hDEADBEEF);
    add(0, 0, 3'd2, 32'h100, 32'h0);
    // byte write merged into word, read forwarded
    add(0, 1, 3'd2, 32'h100, 32'h11223344);
    add(0, 1, 3'd0, 32'h102, 32'h00AB0000);
    add(0, 0, 3'd2, 32'h100, 32'h0);
    // out-of-range, unaligned and oversized writes
    add(0, 1, 3'd2, 32'h1 << AW, 32'hFFFFFFFF);
    add(0, 1, 3'd1, 32'h101, 32'hFFFFFFFF);
    add(0, 1, 3'd3, 32'h100, 32'hFFFFFFFF);
    add(0, 0, 3'd2, 32'h100, 32'h0);
    add(0, 1, 3'd1, 32'h106, 32'hBEEF0000);
    add(0, 0, 3'd2, 32'h104, 32'h0);
    // wait-state slaves
    add(1, 0, 3'd2, 32'h40, 32'h0);
    add(1, 1, 3'd2, 32'h44, 32'hCAFE0001);
    add(1, 0, 3'd2, 32'h44, 32'h0);
    add(0, 0, 3'd2, 32'h100, 32'h0);
    add(2, 1, 3'd2, 32'h200, 32'h00001234);
    for (int k = 0; k < 16; k++) begin
      logic [2:0] sz;
      sz = 3'($urandom_range(0, 2));
      add($urandom_range(0, 1), 1'($urandom_range(0, 1)), sz,
          32'h300 + (32'($urandom_range(0, 15)) << sz), $urandom);
    end
    run_queue();

    u_ws0.read_word(12'h000, d);
    check("err_write_no_commit", d, model[0][0]);

    // reset during the wait states of a write drops it
    @(negedge clk);
    hsel   = 3'b100;
    htrans = 2'b10;
    hwrite = 1'b1;
    hsize  = 3'd2;
    haddr  = 32'h200;
    @(negedge clk);
    hsel   = 3'b000;
    htrans = 2'b00;
    hwdata = 32'h00000055;
    check("ws3_in_wait", {31'd0, hreadyo_v[2]}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("ws3_hreadyo_after_reset", {31'd0, hreadyo_v[2]}, 32'd1);
    check("ws3_hresp_after_reset", {31'd0, hresp_v[2]}, 32'd0);
    check("ws3_hrdata_after_reset", hrdata3, 32'd0);
    repeat (5) @(negedge clk);
    u_ws3.read_word(12'h200, d);
    check("ws3_dropped_write", d, 32'h00001234);

    add(2, 0, 3'd2, 32'h200, 32'h0);
    add(0, 0, 3'd2, 32'h100, 32'h0);
    run_queue();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
